// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests
// to instruction memory and produces {PC+4, instruction} pairs for IF/ID.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_FETCH | request strobe driven for pc this cycle
// S_WAIT  | request outstanding, waiting for imem_rdy (squash drops it)
// S_HOLD  | response captured in hold_buf, waiting for stall to clear
module if_fetch_unit #(
   parameter int unsigned           WORD_SIZE = 32,
   parameter logic [WORD_SIZE-1:0]  RESET_PC  = '0,
   parameter logic [WORD_SIZE-1:0]  NOP_INST  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [WORD_SIZE-1:0]  redirect_pc,
   output logic                  imem_req,
   output logic [WORD_SIZE-1:0]  imem_addr,
   input  logic                  imem_rdy,
   input  logic [WORD_SIZE-1:0]  imem_rdata,
   output logic [WORD_SIZE-1:0]  add4_out,
   output logic [WORD_SIZE-1:0]  inst_out,
   output logic                  if_valid
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t                 state;
   logic [WORD_SIZE-1:0]   pc;
   logic [WORD_SIZE-1:0]   hold_buf;
   logic                   squash;
   logic [WORD_SIZE-1:0]   pc_plus4;
   logic [WORD_SIZE-1:0]   redirect_target;

   assign pc_plus4        = pc + WORD_SIZE'(4);
   assign redirect_target = {redirect_pc[WORD_SIZE-1:2], 2'b00};

   // Request strobe and address follow the state directly so memory sees
   // the request in the same cycle the unit enters FETCH.
   always_comb begin
      imem_req  = (state == S_FETCH) && !rst;
      imem_addr = pc;
   end

   // Fetch sequencing, redirect flush and registered delivery to IF/ID.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FETCH;
         pc       <= RESET_PC;
         squash   <= 1'b0;
         hold_buf <= '0;
         add4_out <= '0;
         inst_out <= '0;
         if_valid <= 1'b0;
      end else begin
         if_valid <= 1'b0;
         if (redirect) begin
            // Redirect wins over stall and delivery; whatever is in flight
            // for the old path must never reach IF/ID.
            pc       <= redirect_target;
            inst_out <= NOP_INST;
            add4_out <= '0;
            unique case (state)
               S_FETCH: begin
                  state  <= S_WAIT;
                  squash <= 1'b1;
               end
               S_WAIT: begin
                  if (imem_rdy) begin
                     state  <= S_FETCH;
                     squash <= 1'b0;
                  end else begin
                     squash <= 1'b1;
                  end
               end
               S_HOLD: begin
                  state    <= S_FETCH;
                  hold_buf <= '0;
               end
               default: state <= S_FETCH;
            endcase
         end else begin
            unique case (state)
               S_FETCH: state <= S_WAIT;
               S_WAIT: begin
                  if (imem_rdy) begin
                     if (squash) begin
                        squash <= 1'b0;
                        state  <= S_FETCH;
                     end else if (!stall) begin
                        inst_out <= imem_rdata;
                        add4_out <= pc_plus4;
                        if_valid <= 1'b1;
                        pc       <= pc_plus4;
                        state    <= S_FETCH;
                     end else begin
                        hold_buf <= imem_rdata;
                        state    <= S_HOLD;
                     end
                  end
               end
               S_HOLD: begin
                  if (!stall) begin
                     inst_out <= hold_buf;
                     add4_out <= pc_plus4;
                     if_valid <= 1'b1;
                     pc       <= pc_plus4;
                     state    <= S_FETCH;
                  end
               end
               default: state <= S_FETCH;
            endcase
         end
      end
   end

endmodule
